// File: rtl/data_sync_launch.sv
// Source-domain launcher for a multi-bit CDC bus synchronizer.
// Holds a word stable on unsync_bus and sequences a level request.
module data_sync_launch #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int USE_ACK     = 1,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    input  logic                 ack_async,
    output logic                 done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam bit ACK_MODE = (USE_ACK != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE
    } state_e;

    state_e                state_q, state_d;
    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic                  en_q, en_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] sync_q;

    logic ack_sync;
    logic accept;
    logic hold_last;

    assign ack_sync   = sync_q[NUM_STAGES-1];
    assign data_ready = (state_q == IDLE);
    assign accept     = data_valid & data_ready;
    assign hold_last  = (cnt_q == CW'(HOLD_CYCLES - 1));

    assign unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign done       = done_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            bus_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[NUM_STAGES-2:0], ack_async};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = REQ;
            end
            REQ: begin
                if (ACK_MODE ? ack_sync : hold_last) state_d = RELEASE;
            end
            RELEASE: begin
                if (ACK_MODE ? !ack_sync : hold_last) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request level is high exactly while in REQ; done marks RELEASE->IDLE.
    always_comb begin
        bus_d  = bus_q;
        en_d   = (state_d == REQ);
        done_d = (state_q == RELEASE) && (state_d == IDLE);
        cnt_d  = cnt_q;
        if (accept) bus_d = data_in;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(HOLD_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

endmodule
